// File: rtl/modulo_entrada_rolhas.sv
// Cork-entry front end: debounces operator buttons, accumulates a requested quantity and issues
// checked one-cycle loads (operator or automatic refill) to the descending tray buffer.
module modulo_entrada_rolhas #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CAP_MAX         = 99,
  parameter int unsigned AUTO_REFILL     = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_inc,
  input  logic       btn_conf,
  input  logic       ve,
  input  logic [6:0] reg_r,
  input  logic       min_r,
  output logic [6:0] qtd,
  output logic       load,
  output logic [6:0] e,
  output logic       rejeitado,
  output logic       ocupado
);

  localparam int unsigned CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [6:0]  QTD_MAX = 7'd99;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] VERIFICA = 2'd1;
  localparam logic [1:0] CARREGA  = 2'd2;
  localparam logic [1:0] REJEITA  = 2'd3;

  // Bit 0 is the increment button, bit 1 the confirm button.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    press;

  assign raw = {btn_conf, btn_inc};

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i]  <= '0;
          filt_q[i] <= ~filt_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Only the filtered rising edge counts as a press; release is silent.
  assign press = filt_q & ~filt_prev_q;

  logic [1:0] state_q, state_d;
  logic [6:0] qtd_q, qtd_d, qtd_inc, e_q, e_d, e_auto;
  logic       rej_q, rej_d, armed_q, armed_d, load_q, load_d, ocupado_q;
  logic [7:0] sum_op, sum_auto;

  assign sum_op   = {1'b0, reg_r} + {1'b0, qtd_q};
  assign sum_auto = {1'b0, reg_r} + 8'(AUTO_REFILL);
  assign e_auto   = (sum_auto > 8'(CAP_MAX)) ? 7'(CAP_MAX) : sum_auto[6:0];
  assign qtd_inc  = (qtd_q >= QTD_MAX) ? QTD_MAX : qtd_q + 7'd1;

  always_comb begin
    state_d = state_q;
    qtd_d   = qtd_q;
    rej_d   = rej_q;
    armed_d = armed_q | ~min_r;
    load_d  = 1'b0;
    e_d     = '0;
    case (state_q)
      OCIOSO: begin
        if (press[0]) begin
          qtd_d = qtd_inc;
          rej_d = 1'b0;
        end
        if (press[1]) rej_d = 1'b0;
        // Confirm wins over the automatic refill in the same cycle.
        if (press[1] && (qtd_d != '0)) begin
          state_d = VERIFICA;
        end else if (min_r && !ve && armed_q) begin
          state_d = CARREGA;
          load_d  = 1'b1;
          e_d     = e_auto;
          armed_d = 1'b0;
        end
      end
      VERIFICA: begin
        if (!ve) begin
          if (sum_op <= 8'(CAP_MAX)) begin
            state_d = CARREGA;
            load_d  = 1'b1;
            e_d     = sum_op[6:0];
            qtd_d   = '0;
            rej_d   = 1'b0;
          end else begin
            state_d = REJEITA;
            rej_d   = 1'b1;
          end
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= OCIOSO;
      qtd_q     <= '0;
      rej_q     <= 1'b0;
      armed_q   <= 1'b1;
      load_q    <= 1'b0;
      e_q       <= '0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtd_q     <= qtd_d;
      rej_q     <= rej_d;
      armed_q   <= armed_d;
      load_q    <= load_d;
      e_q       <= e_d;
      ocupado_q <= (state_d != OCIOSO);
    end
  end

  assign qtd       = qtd_q;
  assign load      = load_q;
  assign e         = e_q;
  assign rejeitado = rej_q;
  assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_modulo_entrada_rolhas.sv
// Randomized bench for modulo_entrada_rolhas against a behavioural model of the button rules
// and the quantity/load policy, compared on every clock.
module tb_modulo_entrada_rolhas;

  localparam int D  = 4;
  localparam int NE = 20000;

  logic       clk = 1'b0;
  logic       clr, btn_inc, btn_conf, ve, min_r;
  logic [6:0] reg_r;
  logic [6:0] qtd, e;
  logic       load, rejeitado, ocupado;

  modulo_entrada_rolhas #(
    .DEBOUNCE_CYCLES(D),
    .CAP_MAX        (99),
    .AUTO_REFILL    (20)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .btn_inc  (btn_inc),
    .btn_conf (btn_conf),
    .ve       (ve),
    .reg_r    (reg_r),
    .min_r    (min_r),
    .qtd      (qtd),
    .load     (load),
    .e        (e),
    .rejeitado(rejeitado),
    .ocupado  (ocupado)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: raw button samples per edge, filtered levels, pending presses, quantity and load policy.
  bit bh [2][NE];
  int en       = 0;
  int rst_edge = 0;
  int t_last [2];
  bit filt   [2];
  bit pend   [2];
  int m_mode;    // 0 idle, 1 checking, 2 loading, 3 rejecting
  int m_qtd, m_e;
  bit m_rej, m_armed, m_load;
  int n_loads = 0;

  function automatic bit synced(input int i, input int k);
    return (k - 2 > rst_edge) ? bh[i][k-2] : 1'b0;
  endfunction

  task automatic model_edge();
    bit inc_p, conf_p, steady;
    int sum;
    if (en >= NE) begin
      $display("FAIL model_budget: got %0d edges expected below %0d", en, NE);
      $fatal(1, "edge budget exhausted");
    end
    bh[0][en] = btn_inc;
    bh[1][en] = btn_conf;
    if (clr) begin
      rst_edge = en;
      for (int i = 0; i < 2; i++) begin
        t_last[i] = en; filt[i] = 1'b0; pend[i] = 1'b0;
      end
      m_mode = 0; m_qtd = 0; m_rej = 1'b0; m_armed = 1'b1; m_load = 1'b0; m_e = 0;
    end else begin
      inc_p  = pend[0];
      conf_p = pend[1];
      // A level flips once the synced input has disagreed with it for D edges since the last flip.
      for (int i = 0; i < 2; i++) begin
        pend[i] = 1'b0;
        if (en - D + 1 > t_last[i]) begin
          steady = 1'b1;
          for (int k = en - D + 1; k <= en; k++)
            if (synced(i, k) == filt[i]) steady = 1'b0;
          if (steady) begin
            filt[i]   = ~filt[i];
            t_last[i] = en;
            pend[i]   = filt[i];
          end
        end
      end
      m_load = 1'b0;
      m_e    = 0;
      if (m_mode == 0) begin
        if (inc_p) begin
          m_qtd = (m_qtd + 1 > 99) ? 99 : m_qtd + 1;
          m_rej = 1'b0;
        end
        if (conf_p) m_rej = 1'b0;
        if (conf_p && m_qtd != 0) m_mode = 1;
        else if (min_r && !ve && m_armed) begin
          m_mode = 2; m_load = 1'b1; m_armed = 1'b0;
          m_e = (int'(reg_r) + 20 > 99) ? 99 : int'(reg_r) + 20;
        end
      end else if (m_mode == 1) begin
        if (!ve) begin
          sum = int'(reg_r) + m_qtd;
          if (sum <= 99) begin
            m_mode = 2; m_load = 1'b1; m_e = sum; m_qtd = 0; m_rej = 1'b0;
          end else begin
            m_mode = 3; m_rej = 1'b1;
          end
        end
      end else begin
        m_mode = 0;
      end
      if (!min_r) m_armed = 1'b1;
    end
    en++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("qtd", qtd, m_qtd);
    check("load", load, m_load);
    check("e", e, m_e);
    check("rejeitado", rejeitado, m_rej);
    check("ocupado", ocupado, (m_mode != 0));
    if (load) begin
      n_loads++;
      check("e_cap", (e <= 7'd99), 1);
    end
  endtask

  task automatic press(input int i, input int hold, input int gap);
    if (i == 0) btn_inc = 1'b1; else btn_conf = 1'b1;
    repeat (hold) step();
    if (i == 0) btn_inc = 1'b0; else btn_conf = 1'b0;
    repeat (gap) step();
  endtask

  task automatic bounce(input int i);
    for (int t = 0; t < 6; t++) begin
      if (i == 0) btn_inc = ~btn_inc; else btn_conf = ~btn_conf;
      repeat ($urandom_range(1, D - 1)) step();
    end
    press(i, D + 3, D + 3);
  endtask

  task automatic set_env();
    ve    = ($urandom_range(0, 3) == 0);
    min_r = ($urandom_range(0, 2) == 0);
    reg_r = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 60));
  endtask

  initial begin
    clr = 1'b1; btn_inc = 1'b0; btn_conf = 1'b0; ve = 1'b0; min_r = 1'b0; reg_r = 7'd30;
    repeat (2) step();
    clr = 1'b0;
    repeat (3) step();

    // Clean press: quantity appears D+3 edges after the press is first sampled.
    btn_inc = 1'b1;
    repeat (D + 2) step();
    check("qtd_before_latency", qtd, 0);
    step();
    check("qtd_at_latency", qtd, 1);
    btn_inc = 1'b0;
    repeat (D + 3) step();

    // Saturation: far more presses than the quantity can hold.
    for (int p = 0; p < 110; p++) press(0, D + 1, D + 1);
    check("qtd_saturated", qtd, 99);
    check("no_load_yet", n_loads, 0);

    // Oversized request against a nearly full tray must be refused.
    reg_r = 7'd80;
    press(1, D + 2, D + 4);
    check("reject_flag", rejeitado, 1);
    check("reject_keeps_qtd", qtd, 99);

    for (int s = 0; s < 70; s++) begin
      set_env();
      case ($urandom_range(0, 9))
        0, 1, 2: for (int p = 0; p < $urandom_range(1, 30); p++) press(0, D + $urandom_range(0, 3), D + $urandom_range(0, 3));
        3, 4:    press(1, D + $urandom_range(0, 4), D + $urandom_range(2, 12));
        5:       bounce($urandom_range(0, 1));
        6: begin
          clr = 1'b1;
          step();
          clr = 1'b0;
        end
        default: repeat ($urandom_range(3, 15)) step();
      endcase
    end

    // Drain with buttons released and the tray above minimum.
    btn_inc = 1'b0; btn_conf = 1'b0; ve = 1'b0; min_r = 1'b0;
    repeat (20) step();
    check("idle_at_end", ocupado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
